// File: rtl/round_iter_pkg.sv
// Shared AES-128 definitions for round_iter: widths, FSM encoding, S-box,
// round constants and the SubBytes/ShiftRows/MixColumns transforms.
package round_iter_pkg;

   localparam int BLK_W     = 128;
   localparam int NR_AES128 = 10;

   typedef logic [0:BLK_W-1] blk_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_OUT   = 2'd2
   } fsm_e;

   // Byte n of the forward S-box sits at bits [8n +: 8] (row-major, 0x00 first).
   localparam logic [0:2047] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[{b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [0:31] sub_word(input logic [0:31] w);
      return {sbox(w[0:7]), sbox(w[8:15]), sbox(w[16:23]), sbox(w[24:31])};
   endfunction

   function automatic blk_t sub_bytes(input blk_t x);
      blk_t o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(x[8*i +: 8]);
      return o;
   endfunction

   // Byte index is row + 4*column; row r rotates left by r columns.
   function automatic blk_t shift_rows(input blk_t x);
      blk_t o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(r+4*c) +: 8] = x[8*(r+4*((c+r)%4)) +: 8];
      return o;
   endfunction

   function automatic blk_t mix_columns(input blk_t x);
      blk_t o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = x[32*c      +: 8];
         a1 = x[32*c + 8  +: 8];
         a2 = x[32*c + 16 +: 8];
         a3 = x[32*c + 24 +: 8];
         o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

endpackage

// File: rtl/round_iter_if.sv
// Request/result bundle between a round_iter instance and its driver.
interface round_iter_if;
   import round_iter_pkg::*;

   logic iEn;
   logic iStart;
   blk_t iPlaintext;
   blk_t iKey;
   blk_t oState;
   blk_t oKey;
   logic oDo;
   logic oBusy;

   modport master (
      output iEn, iStart, iPlaintext, iKey,
      input  oState, oKey, oDo, oBusy
   );

   modport slave (
      input  iEn, iStart, iPlaintext, iKey,
      output oState, oKey, oDo, oBusy
   );
endinterface

// File: rtl/key_expand_step.sv
// One AES-128 key-schedule step: derives the next round key from the
// current one and a round constant. Purely combinational.
module key_expand_step
   import round_iter_pkg::*;
(
   input  blk_t       iKey,
   input  logic [7:0] iRcon,
   output blk_t       oKey
);

   logic [0:31] w [4];
   logic [0:31] rot_w;
   logic [0:31] nw0, nw1, nw2, nw3;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_words
         assign w[gi] = iKey[32*gi +: 32];
      end
   endgenerate

   assign rot_w = {w[3][8:31], w[3][0:7]};
   assign nw0   = w[0] ^ sub_word(rot_w) ^ {iRcon, 24'h000000};
   assign nw1   = w[1] ^ nw0;
   assign nw2   = w[2] ^ nw1;
   assign nw3   = w[3] ^ nw2;
   assign oKey  = {nw0, nw1, nw2, nw3};

endmodule

// File: rtl/round_iter.sv
// Iterative AES-128 front end: initial AddRoundKey plus rounds 1..9 with an
// on-the-fly key schedule. ROUND_ITER_DBG_EN adds the oRound debug port.
module round_iter
   import round_iter_pkg::*;
#(
   parameter int NR = NR_AES128
) (
   input  logic       iClk,
   input  logic       iRst_n,
`ifdef ROUND_ITER_DBG_EN
   output logic [3:0] oRound,
`endif
   round_iter_if.slave bus
);

   localparam logic [3:0] LAST_ROUND = 4'(NR - 1);

   fsm_e       fsm_q, fsm_d;
   blk_t       state_q, state_d;
   blk_t       key_q, key_d;
   logic [3:0] round_q, round_d;
   blk_t       nk;
   logic [7:0] rcon_sel;

   // The single expander also produces the round-10 key shown during OUT.
   assign rcon_sel = (fsm_q == S_OUT) ? 8'h36 : rcon(round_q);

   key_expand_step u_key_expand_step (
      .iKey  (key_q),
      .iRcon (rcon_sel),
      .oKey  (nk)
   );

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         fsm_q   <= S_IDLE;
         state_q <= '0;
         key_q   <= '0;
         round_q <= '0;
      end else if (bus.iEn) begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         key_q   <= key_d;
         round_q <= round_d;
      end
   end

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      key_d   = key_q;
      round_d = round_q;
      case (fsm_q)
         S_IDLE: begin
            if (bus.iStart) begin
               state_d = bus.iPlaintext ^ bus.iKey;
               key_d   = bus.iKey;
               round_d = 4'd1;
               fsm_d   = S_ROUND;
            end
         end
         S_ROUND: begin
            state_d = mix_columns(shift_rows(sub_bytes(state_q))) ^ nk;
            key_d   = nk;
            round_d = round_q + 4'd1;
            if (round_q == LAST_ROUND) fsm_d = S_OUT;
         end
         S_OUT: begin
            round_d = 4'd0;
            fsm_d   = S_IDLE;
         end
         default: begin
            round_d = 4'd0;
            fsm_d   = S_IDLE;
         end
      endcase
   end

   always_comb begin
      bus.oDo    = 1'b0;
      bus.oBusy  = (fsm_q == S_ROUND) || (fsm_q == S_OUT);
      bus.oState = '0;
      bus.oKey   = '0;
      if (fsm_q == S_OUT) begin
         bus.oDo    = 1'b1;
         bus.oState = state_q;
         bus.oKey   = nk;
      end
   end

`ifdef ROUND_ITER_DBG_EN
   assign oRound = round_q;
`endif

endmodule

// File: tb/tb_round_iter.sv
// Scoreboard bench for round_iter: an independent byte-level AES model
// predicts each block; a negedge monitor checks every oDo the DUT presents.
module tb_round_iter;

   typedef struct {
      logic [127:0] st9;
      logic [127:0] k10;
      logic [127:0] ct;
   } exp_t;

   localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic clk = 1'b0;
   logic rst_n;
   int   total    = 0;
   int   bad      = 0;
   int   done_cnt = 0;
   int   exp_done = 0;
   bit   mon_en   = 1'b0;
   exp_t sb_q[$];
   logic [7:0] sbox_m [256];

   round_iter_if bus ();
`ifdef ROUND_ITER_DBG_EN
   logic [3:0] round_dbg;
`endif

   round_iter dut (
      .iClk   (clk),
      .iRst_n (rst_n),
`ifdef ROUND_ITER_DBG_EN
      .oRound (round_dbg),
`endif
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b};
      return d[15-n -: 8];
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                         ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                              input bit do_mix);
      logic [7:0] a [16];
      logic [7:0] b [16];
      logic [7:0] acc, coef;
      logic [127:0] o;
      int d;
      for (int i = 0; i < 16; i++) a[i] = sbox_m[st[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) begin
               d    = (k - r + 4) % 4;
               coef = (d == 0) ? 8'h02 : (d == 1) ? 8'h03 : 8'h01;
               acc  = acc ^ gmul(coef, b[k+4*c]);
            end
            a[r+4*c] = do_mix ? acc : b[r+4*c];
         end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i] ^ rk[127-8*i -: 8];
      return o;
   endfunction

   function automatic exp_t aes_model(input logic [127:0] pt, input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      logic [127:0] st;
      exp_t e;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]}
                 ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      st = pt ^ key;
      for (int r = 1; r <= 9; r++)
         st = aes_round(st, {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]}, 1'b1);
      e.st9 = st;
      e.k10 = {w[40], w[41], w[42], w[43]};
      e.ct  = aes_round(st, e.k10, 1'b0);
      return e;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic cycle(input logic en);
      bus.iEn = en;
      @(posedge clk);
      #1;
   endtask

   // Monitor: outputs must be zero outside OUT; each enabled OUT cycle is one result.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (mon_en) begin
         if (bus.oDo !== 1'b1) begin
            chk("idle_state_zero", bus.oState, '0);
            chk("idle_key_zero", bus.oKey, '0);
         end else if (bus.iEn === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
               chk("unexpected_oDo", 128'(done_cnt), 128'(exp_done));
            end else begin
               e = sb_q.pop_front();
               chk("oState", bus.oState, e.st9);
               chk("oKey", bus.oKey, e.k10);
               chk("ciphertext", aes_round(bus.oState, bus.oKey, 1'b0), e.ct);
`ifdef ROUND_ITER_DBG_EN
               chk("oRound_out", 128'(round_dbg), 128'd10);
`endif
               $display("tx %0d: state=%h key=%h ct=%h", done_cnt, bus.oState, bus.oKey,
                        aes_round(bus.oState, bus.oKey, 1'b0));
            end
         end
      end
   end

   task automatic run_tx(input logic [127:0] pt, input logic [127:0] key,
                         input bit use_k, input logic [127:0] k_ref,
                         input bit use_ct, input logic [127:0] ct_ref,
                         input bit stall, input bit ign);
      exp_t e;
      int   cnt;
      int   guard;
      logic en;
      e = aes_model(pt, key);
      if (use_k)  e.k10 = k_ref;
      if (use_ct) e.ct  = ct_ref;
      sb_q.push_back(e);
      exp_done++;
      bus.iPlaintext = pt;
      bus.iKey       = key;
      bus.iStart     = 1'b1;
      cycle(1'b1);
      bus.iStart     = 1'b0;
      bus.iPlaintext = rand128();
      bus.iKey       = rand128();
      cnt   = 0;
      guard = 0;
      while (cnt < 10 && guard < 500) begin
         chk("busy_during", 128'(bus.oBusy), 128'd1);
         chk("oDo_timing", 128'(bus.oDo), 128'(cnt == 9));
         en = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.iStart = ign && (cnt == 4 || cnt == 9);
         if (bus.iStart) begin
            bus.iKey       = rand128();
            bus.iPlaintext = rand128();
         end
         cycle(en);
         if (en) cnt++;
         guard++;
      end
      bus.iStart = 1'b0;
      if (cnt < 10) chk("tx_timeout", 128'(cnt), 128'd10);
      chk("busy_after", 128'(bus.oBusy), 128'd0);
      chk("oDo_after", 128'(bus.oDo), 128'd0);
   endtask

   initial begin
      build_sbox();
      rst_n          = 1'b0;
      bus.iEn        = 1'b0;
      bus.iStart     = 1'b0;
      bus.iPlaintext = '0;
      bus.iKey       = '0;
      repeat (3) cycle(1'b0);
      chk("rst_oDo", 128'(bus.oDo), 128'd0);
      chk("rst_oBusy", 128'(bus.oBusy), 128'd0);
      chk("rst_oState", bus.oState, '0);
      chk("rst_oKey", bus.oKey, '0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      cycle(1'b1);

      // App.B and App.C.1 with iEn held high: exact latency and busy window.
      run_tx(B_PT, B_KEY, 1'b1, B_K10, 1'b1, B_CT, 1'b0, 1'b0);
      run_tx(C_PT, C_KEY, 1'b0, '0, 1'b1, C_CT, 1'b0, 1'b0);
      // App.B with iEn toggling.
      run_tx(B_PT, B_KEY, 1'b1, B_K10, 1'b1, B_CT, 1'b1, 1'b0);

      // Abort in round 5, then a clean App.C.1 run.
      bus.iPlaintext = B_PT;
      bus.iKey       = B_KEY;
      bus.iStart     = 1'b1;
      cycle(1'b1);
      bus.iStart = 1'b0;
      repeat (4) cycle(1'b1);
      chk("abort_pre_busy", 128'(bus.oBusy), 128'd1);
      rst_n = 1'b0;
      cycle(1'b1);
      chk("abort_oBusy", 128'(bus.oBusy), 128'd0);
      chk("abort_oDo", 128'(bus.oDo), 128'd0);
      chk("abort_oState", bus.oState, '0);
      chk("abort_oKey", bus.oKey, '0);
`ifdef ROUND_ITER_DBG_EN
      chk("abort_oRound", 128'(round_dbg), 128'd0);
`endif
      rst_n = 1'b1;
      cycle(1'b1);
      run_tx(C_PT, C_KEY, 1'b0, '0, 1'b1, C_CT, 1'b0, 1'b0);

      // Start requests during ROUND and OUT must be dropped.
      run_tx(B_PT, B_KEY, 1'b1, B_K10, 1'b1, B_CT, 1'b1, 1'b1);
      repeat (12) begin
         chk("ignored_start_idle", 128'(bus.oBusy), 128'd0);
         cycle(1'b1);
      end

      for (int n = 0; n < 12; n++) begin
         run_tx(rand128(), rand128(), 1'b0, '0, 1'b0, '0,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) cycle(1'($urandom_range(0, 1)));
      end

      repeat (4) cycle(1'b1);
      chk("done_count", 128'(done_cnt), 128'(exp_done));
      chk("queue_empty", 128'(sb_q.size()), 128'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
